rom_load_ctrl: RTL

- Sequences the HPS ROM download stream into the game core's ROM regions.
- Decodes each download byte to a region select and a region-local address.
- Presents each byte over a valid/ready write port, so a slow shared memory can back-pressure the stream.
- Owns the core reset during and after loading; sits between hps_io ioctl outputs and FPGA_SOLOMON ROM write ports.

---
 rtl/rom_load_pkg.sv | 26 ++
 rtl/rom_load_ctrl_if.sv | 28 ++
 rtl/rom_region_dec.sv | 32 +++
 rtl/rom_load_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rom_load_pkg.sv
// Shared ROM region map, FSM state encoding and region index type for the
// ROM download controller.
package rom_load_pkg;

  localparam int REG_COUNT = 5;

  typedef logic [2:0] region_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } state_t;

  // Regions: main CPU, sound CPU, FG tiles, BG tiles, sprites.
  localparam logic [24:0] REG_BASE [REG_COUNT] = '{
    25'h00000, 25'h0C000, 25'h10000, 25'h18000, 25'h20000
  };

  localparam logic [24:0] REG_SIZE [REG_COUNT] = '{
    25'h0C000, 25'h04000, 25'h08000, 25'h08000, 25'h08000
  };

endpackage

// File: rtl/rom_load_ctrl_if.sv
// Valid/ready ROM write port between the download controller (master) and
// the shared ROM memory (slave).
interface rom_load_ctrl_if;
  import rom_load_pkg::*;

  logic        WR_VALID;
  logic        WR_READY;
  region_t     WR_REGION;
  logic [15:0] WR_ADDR;
  logic [7:0]  WR_DATA;

  modport master (
    output WR_VALID,
    input  WR_READY,
    output WR_REGION,
    output WR_ADDR,
    output WR_DATA
  );

  modport slave (
    input  WR_VALID,
    output WR_READY,
    input  WR_REGION,
    input  WR_ADDR,
    input  WR_DATA
  );

endinterface

// File: rtl/rom_region_dec.sv
// Combinational decode of a download byte address into region index,
// region-local address and an in-range flag.
module rom_region_dec
  import rom_load_pkg::*;
#(
  parameter int NREG = 5
) (
  input  logic [24:0] addr,
  output region_t     region,
  output logic [15:0] local_addr,
  output logic        in_range
);

  logic [24:0] offset;

  // Later entries override earlier ones, so the highest matching index wins.
  always_comb begin
    region   = '0;
    offset   = '0;
    in_range = 1'b0;
    for (int i = 0; i < NREG && i < REG_COUNT; i++) begin
      if (addr >= REG_BASE[i] && addr < REG_BASE[i] + REG_SIZE[i]) begin
        region   = region_t'(i);
        offset   = addr - REG_BASE[i];
        in_range = 1'b1;
      end
    end
  end

  assign local_addr = offset[15:0];

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the HPS ROM download into the core's ROM regions through a
// one-entry valid/ready buffer and owns the core reset. Optional running
// checksum output enabled by defining ROM_CKSUM_EN.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int RST_HOLD = 16,
  parameter int NREG     = 5
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          DL_ACTIVE,
  input  logic          DL_WR,
  input  logic [24:0]   DL_ADDR,
  input  logic [7:0]    DL_DATA,
  rom_load_ctrl_if.master wr,
  output logic          CORE_RST,
  output logic          LOAD_DONE,
  output logic          OVERRUN,
  output logic          IGNORED
`ifdef ROM_CKSUM_EN
  ,
  output logic [15:0]   CKSUM
`endif
);

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

  state_t      state;
  logic [15:0] hold_cnt;
  logic        core_rst;
  logic        load_done;
  logic        overrun;
  logic        ignored;

  region_t     dec_region;
  logic [15:0] dec_addr;
  logic        dec_hit;

  logic        vld_p1;
  region_t     region_p1;
  logic [15:0] addr_p1;
  logic [7:0]  data_p1;

  logic        accept_window;
  logic        strobe;
  logic        wr_fire;
  logic        capture;
  logic        drop;
  logic        out_of_range;
  logic        reload;
  logic        enter_load;

  rom_region_dec #(
    .NREG(NREG)
  ) u_dec (
    .addr       (DL_ADDR),
    .region     (dec_region),
    .local_addr (dec_addr),
    .in_range   (dec_hit)
  );

  assign accept_window = (state == IDLE) || (state == LOAD);
  assign strobe        = accept_window && DL_WR;
  assign wr_fire       = vld_p1 && wr.WR_READY;
  // A full buffer that is being drained this cycle can take the new byte.
  assign capture       = strobe && dec_hit && (!vld_p1 || wr.WR_READY);
  assign drop          = strobe && dec_hit && vld_p1 && !wr.WR_READY;
  assign out_of_range  = strobe && !dec_hit;
  assign reload        = DL_ACTIVE && ((state == HOLD) || (state == RUN));
  assign enter_load    = reload || ((state == IDLE) && DL_ACTIVE);

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      overrun   <= 1'b0;
      ignored   <= 1'b0;
    end else begin
      if (drop)         overrun <= 1'b1;
      if (out_of_range) ignored <= 1'b1;
      case (state)
        IDLE:  if (DL_ACTIVE) state <= LOAD;
        LOAD:  if (!DL_ACTIVE) state <= DRAIN;
        DRAIN: begin
          // Leave as the last write completes so the hold window starts
          // right after it.
          if (!vld_p1 || wr_fire) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (DL_ACTIVE) begin
            state     <= LOAD;
            hold_cnt  <= '0;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            overrun   <= 1'b0;
            ignored   <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            core_rst  <= 1'b0;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        RUN: begin
          if (DL_ACTIVE) begin
            state     <= LOAD;
            hold_cnt  <= '0;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            overrun   <= 1'b0;
            ignored   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: single-entry write buffer
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      vld_p1    <= 1'b0;
      region_p1 <= '0;
      addr_p1   <= '0;
      data_p1   <= '0;
    end else if (capture) begin
      vld_p1    <= 1'b1;
      region_p1 <= dec_region;
      addr_p1   <= dec_addr;
      data_p1   <= DL_DATA;
    end else if (wr_fire) begin
      vld_p1    <= 1'b0;
    end
  end

`ifdef ROM_CKSUM_EN
  logic [15:0] cksum;

  always_ff @(posedge MCLK) begin
    if (RESET || enter_load) begin
      cksum <= '0;
    end else if (((state == LOAD) || (state == DRAIN)) && wr_fire) begin
      cksum <= cksum + {8'h00, data_p1};
    end
  end

  assign CKSUM = cksum;
`endif

  assign wr.WR_VALID  = vld_p1;
  assign wr.WR_REGION = region_p1;
  assign wr.WR_ADDR   = addr_p1;
  assign wr.WR_DATA   = data_p1;
  assign CORE_RST     = core_rst;
  assign LOAD_DONE    = load_done;
  assign OVERRUN      = overrun;
  assign IGNORED      = ignored;

endmodule
